// File: rtl/c2c_r_arbiter_pkg.sv
// Shared types for the c2c_r read-port arbiter.
package c2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/c2c_r_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after last_i+1, with wrap.
module rr_pick #(
  parameter  int unsigned NUM_M = 2,
  localparam int unsigned IW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [IW-1:0]    grant_o,
  output logic             valid_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned off = NUM_M; off >= 1; off--) begin
      idx = IW'((32'(last_i) + off) % NUM_M);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c2c_r_arbiter.sv
// Round-robin arbiter letting NUM_M c2c_r masters share one slave read port.
module c2c_r_arbiter
  import c2c_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NUM_M = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_M-1:0]          m_re,
  input  logic [NUM_M*(XLEN/8)-1:0] m_sel,
  input  logic [NUM_M*XLEN-1:0]     m_addr,
  output logic [NUM_M-1:0]          m_ack,
  output logic [XLEN-1:0]           m_data,
  output logic                      s_re,
  output logic [XLEN/8-1:0]         s_sel,
  output logic [XLEN-1:0]           s_addr,
  input  logic                      s_ack,
  input  logic [XLEN-1:0]           s_data
);

  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned IW = $clog2(NUM_M);

  arb_state_e        state_q;
  logic [IW-1:0]     last_q;
  logic              s_re_q;
  logic [SW-1:0]     s_sel_q;
  logic [XLEN-1:0]   s_addr_q;
  logic [NUM_M-1:0]  m_ack_q;
  logic [XLEN-1:0]   m_data_q;

  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [SW-1:0]     pick_sel;
  logic [XLEN-1:0]   pick_addr;
  logic [NUM_M-1:0]  ack_vec;

  rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .req_i   (m_re),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  // last_q doubles as the in-flight grant, since it is only updated on a grant.
  always_comb begin
    pick_sel  = '0;
    pick_addr = '0;
    ack_vec   = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_sel  = m_sel[i*SW +: SW];
        pick_addr = m_addr[i*XLEN +: XLEN];
      end
      ack_vec[i] = (last_q == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= IW'(NUM_M - 1);
      s_re_q   <= 1'b0;
      s_sel_q  <= '0;
      s_addr_q <= '0;
      m_ack_q  <= '0;
      m_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            last_q   <= pick_idx;
            s_sel_q  <= pick_sel;
            s_addr_q <= pick_addr;
            s_re_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (s_ack) begin
            m_data_q <= s_data;
            m_ack_q  <= ack_vec;
            s_re_q   <= 1'b0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          m_ack_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack  = m_ack_q;
  assign m_data = m_data_q;
  assign s_re   = s_re_q;
  assign s_sel  = s_sel_q;
  assign s_addr = s_addr_q;

endmodule

// File: doc/c2c_r_arbiter.md
C2C_R_ARBITER -- requirements
Module: c2c_r_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width in bits.
REQ-002 SHALL have parameter NUM_M, default 2, meaning number of c2c_r masters sharing one slave port; legal range 2..8.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_re  input  NUM_M  per-master read request.
REQ-006 SHALL have port m_sel  input  NUM_M x XLEN/8  per-master byte select.
REQ-007 SHALL have port m_addr  input  NUM_M x XLEN  per-master address.
REQ-008 SHALL have port m_ack  output  NUM_M  per-master response strobe, one-hot or zero.
REQ-009 SHALL have port m_data  output  XLEN  shared response data, valid only with an m_ack bit.
REQ-010 SHALL have port s_re  output  1  slave read request.
REQ-011 SHALL have port s_sel  output  XLEN/8  slave byte select.
REQ-012 SHALL have port s_addr  output  XLEN  slave address.
REQ-013 SHALL have port s_ack  input  1  slave response strobe, one-cycle pulse.
REQ-014 SHALL have port s_data  input  XLEN  slave read data, valid with s_ack.

Function
REQ-015 Protocol: a master SHALL hold m_re, m_sel and m_addr stable from assertion until the cycle its m_ack is high; the slave holds s_ack high for exactly one cycle per s_re transaction.
REQ-016 SHALL implement FSM states IDLE, REQ, RESP; at most one transaction outstanding.
REQ-017 IDLE: if any m_re bit is set, SHALL grant one master by round-robin, latch its sel/addr into s_sel/s_addr, set s_re=1, and go to REQ at the same edge; otherwise remain in IDLE with s_re=0.
REQ-018 Round-robin: search SHALL start at (last_grant+1) mod NUM_M and ascend with wrap; last_grant updates on every grant.
REQ-019 REQ: s_re, s_sel and s_addr SHALL stay constant; on s_ack=1, SHALL register m_data<=s_data, set m_ack[grant]=1, clear s_re, and go to RESP.
REQ-020 RESP: m_ack SHALL be high for exactly this one cycle, then clear; the FSM returns to IDLE at the next edge.
REQ-021 m_data SHALL hold its last value outside RESP; it is not cleared.
REQ-022 Latency: m_re sampled in cycle c gives s_re high in c+1; s_ack in cycle d gives m_ack high in d+1; minimum round trip is m_re at c to m_ack at c+2.
REQ-023 A request issued by a master in the cycle after its m_ack SHALL be arbitrated normally, so back-to-back transactions are sustained every 3 cycles.
REQ-024 s_ack while in IDLE or RESP SHALL be ignored, with no m_ack and no m_data update.
REQ-025 If the granted master drops m_re while in REQ (protocol violation), SHALL still complete the slave transaction and pulse m_ack[grant].
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, s_re=0, s_sel=0, s_addr=0, m_ack=0, m_data=0, last_grant=NUM_M-1, so master 0 has first priority.
REQ-028 Reset asserted in REQ or RESP SHALL abandon the transaction; an s_ack arriving after reset release with the FSM in IDLE falls under REQ-024.

Structure
REQ-029 Package c2c_pkg SHALL hold the arb_state_e typedef (IDLE, REQ, RESP).
REQ-030 The round-robin pick SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: grant index, valid), parametrised by NUM_M.
REQ-031 Grant index width SHALL be $clog2(NUM_M).

Verification
REQ-032 Single request: NUM_M=2; m_re[0]=1 at c, addr 0x100, sel 0xF; slave acks in c+1 with 0xDEADBEEF -> s_re high only in c+1, s_addr=0x100; m_ack=2'b01 and m_data=0xDEADBEEF at c+2.
REQ-033 Contention: m_re=2'b11 held continuously after reset -> grant order 0,1,0,1; each master is acked once every two transactions.
REQ-034 Wrap: NUM_M=3, last_grant=2, m_re=3'b101 -> master 0 granted, then master 2.
REQ-035 Slow slave: s_ack delayed 5 cycles -> s_re/s_addr stable for all 5 cycles; m_ack appears one cycle after s_ack.
REQ-036 Spurious ack: s_ack=1 in IDLE with s_data=0x55 -> m_ack stays 0 and m_data is unchanged.
REQ-037 Mid-transaction reset: reset_n low in REQ -> s_re=0 immediately; after release, first grant goes to master 0.
